// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory subsystem (mem_arbiter, mem_ctrl).
//   ADDR_W      : RAM address width
//   DATA_W      : RAM data width
//   LOCK_MAX    : idle cycles a lock may be held before it is broken
//   arb_state_e : arbiter state encoding (IDLE=00, LOCK0=01, LOCK1=10)
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOCK0 = 2'b01,
    ST_LOCK1 = 2'b10
  } arb_state_e;

endpackage : mem_pkg

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter in front of a single-port synchronous RAM.
// Requester 0 is the input loader, requester 1 the FPU operand fetch.
// Grants are zero-cycle (ready is combinational), round-robin when both
// request in IDLE, and a requester may hold the RAM across beats with rqN_lock.
// A lock left idle for LOCK_MAX cycles is broken and arb_lock_err is set.
//
// Ports
//   mc_clk, mc_reset          : clock, asynchronous active-high reset
//   rqN_valid/we/addr/wdata   : beat request from requester N
//   rqN_lock                  : keep the grant after this beat
//   rqN_ready                 : beat accepted this cycle
//   rqN_rvalid, rqN_rdata     : read return, one cycle after acceptance
//   mem_en/we/addr/wdata      : RAM command (combinational copy of granted beat)
//   mem_rdata                 : RAM read data, one cycle after a read strobe
//   arb_owner                 : index of the last accepted requester
//   arb_lock_err              : sticky lock-timeout flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W   = mem_pkg::ADDR_W,
  parameter int DATA_W   = mem_pkg::DATA_W,
  parameter int LOCK_MAX = mem_pkg::LOCK_MAX
) (
  input  logic              mc_clk,
  input  logic              mc_reset,

  input  logic              rq0_valid,
  input  logic              rq0_we,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic              rq0_lock,
  output logic              rq0_ready,
  output logic              rq0_rvalid,
  output logic [DATA_W-1:0] rq0_rdata,

  input  logic              rq1_valid,
  input  logic              rq1_we,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  input  logic              rq1_lock,
  output logic              rq1_ready,
  output logic              rq1_rvalid,
  output logic [DATA_W-1:0] rq1_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              arb_owner,
  output logic              arb_lock_err
);

  import mem_pkg::*;

  // The idle counter is 8 bits wide; the timeout fires on the LOCK_MAX-th idle cycle.
  localparam logic [7:0] IDLE_LAST = 8'(LOCK_MAX - 1);

  arb_state_e r_state, w_nxt_state;
  logic       r_ptr, w_nxt_ptr;
  logic [7:0] r_idle_cnt, w_nxt_idle_cnt;
  logic       r_lock_err, w_nxt_lock_err;
  logic       r_owner;
  logic       r_rd_pend;
  logic       r_rd_tag;

  logic       w_rdy0, w_rdy1;
  logic       w_acc;      // a beat is accepted this cycle
  logic       w_gnt;      // index of the accepted requester (valid with w_acc)
  logic       w_gnt_we;
  logic       w_gnt_lock;

  // ---------------------------------------------------------------------------
  // Grant: ready already implies valid, so ready doubles as acceptance.
  // Readies are held low during reset so the RAM sees no strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    if (!mc_reset) begin
      unique case (r_state)
        ST_IDLE: begin
          if (rq0_valid && rq1_valid) begin
            w_rdy0 = ~r_ptr;
            w_rdy1 = r_ptr;
          end else begin
            w_rdy0 = rq0_valid;
            w_rdy1 = rq1_valid;
          end
        end
        ST_LOCK0: w_rdy0 = rq0_valid;
        ST_LOCK1: w_rdy1 = rq1_valid;
        default:  ;
      endcase
    end
  end

  assign w_acc      = w_rdy0 | w_rdy1;
  assign w_gnt      = w_rdy1;
  assign w_gnt_we   = w_gnt ? rq1_we   : rq0_we;
  assign w_gnt_lock = w_gnt ? rq1_lock : rq0_lock;

  assign rq0_ready  = w_rdy0;
  assign rq1_ready  = w_rdy1;

  assign mem_en     = w_acc;
  assign mem_we     = w_acc & w_gnt_we;
  assign mem_addr   = w_acc ? (w_gnt ? rq1_addr  : rq0_addr)  : '0;
  assign mem_wdata  = w_acc ? (w_gnt ? rq1_wdata : rq0_wdata) : '0;

  // ---------------------------------------------------------------------------
  // Next state: lock entry/exit, round-robin pointer, lock idle timeout.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_ptr      = r_ptr;
    w_nxt_idle_cnt = r_idle_cnt;
    w_nxt_lock_err = r_lock_err;

    unique case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          w_nxt_ptr      = ~w_gnt;
          w_nxt_idle_cnt = '0;
          if (w_gnt_lock) w_nxt_state = w_gnt ? ST_LOCK1 : ST_LOCK0;
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (w_acc) begin
          w_nxt_idle_cnt = '0;
          if (!w_gnt_lock) begin
            w_nxt_state = ST_IDLE;
            w_nxt_ptr   = ~w_gnt;
          end
        end else if (r_idle_cnt == IDLE_LAST) begin
          // Lock holder went quiet too long: hand priority to the other side.
          w_nxt_state    = ST_IDLE;
          w_nxt_ptr      = (r_state == ST_LOCK0);
          w_nxt_idle_cnt = '0;
          w_nxt_lock_err = 1'b1;
        end else begin
          w_nxt_idle_cnt = r_idle_cnt + 8'd1;
        end
      end
      default: begin
        w_nxt_state    = ST_IDLE;
        w_nxt_idle_cnt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset also drops any read in flight, so no rvalid can
  // appear after reset release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mc_clk or posedge mc_reset) begin
    if (mc_reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 1'b0;
      r_idle_cnt <= '0;
      r_lock_err <= 1'b0;
      r_owner    <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_tag   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all sequential state, so every
      // register samples pre-edge values regardless of statement order.
      r_state    <= w_nxt_state;
      r_ptr      <= w_nxt_ptr;
      r_idle_cnt <= w_nxt_idle_cnt;
      r_lock_err <= w_nxt_lock_err;
      r_rd_pend  <= w_acc & ~w_gnt_we;
      if (w_acc) begin
        r_owner  <= w_gnt;
        r_rd_tag <= w_gnt;
      end
    end
  end

  // Read return: the RAM answers one cycle after the strobe, routed by tag.
  assign rq0_rvalid   = r_rd_pend & ~r_rd_tag;
  assign rq1_rvalid   = r_rd_pend &  r_rd_tag;
  assign rq0_rdata    = rq0_rvalid ? mem_rdata : '0;
  assign rq1_rdata    = rq1_rvalid ? mem_rdata : '0;

  assign arb_owner    = r_owner;
  assign arb_lock_err = r_lock_err;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Drives both requesters cycle by cycle, predicts grants, RAM commands, owner
// and lock-error from a transaction-level model, and queues expected read
// returns for a separate monitor that checks rvalid/rdata every cycle.
// A behavioural RAM sits beside the DUT.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int AW    = ADDR_W;
  localparam int DW    = DATA_W;
  localparam int LM    = LOCK_MAX;
  localparam int DEPTH = 1 << AW;
  localparam int VW    = 4 + AW + DW + 2;

  typedef struct {
    bit            v;
    bit            we;
    bit            lk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } rq_t;

  typedef struct {
    int            cyc;
    int            who;
    logic [DW-1:0] data;
  } exp_t;

  logic          mc_clk = 1'b0;
  logic          mc_reset;
  logic          rq0_valid, rq0_we, rq0_lock, rq0_ready, rq0_rvalid;
  logic [AW-1:0] rq0_addr;
  logic [DW-1:0] rq0_wdata, rq0_rdata;
  logic          rq1_valid, rq1_we, rq1_lock, rq1_ready, rq1_rvalid;
  logic [AW-1:0] rq1_addr;
  logic [DW-1:0] rq1_wdata, rq1_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          arb_owner, arb_lock_err;

  always #5 mc_clk = ~mc_clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
    .mc_clk      (mc_clk),
    .mc_reset    (mc_reset),
    .rq0_valid   (rq0_valid),
    .rq0_we      (rq0_we),
    .rq0_addr    (rq0_addr),
    .rq0_wdata   (rq0_wdata),
    .rq0_lock    (rq0_lock),
    .rq0_ready   (rq0_ready),
    .rq0_rvalid  (rq0_rvalid),
    .rq0_rdata   (rq0_rdata),
    .rq1_valid   (rq1_valid),
    .rq1_we      (rq1_we),
    .rq1_addr    (rq1_addr),
    .rq1_wdata   (rq1_wdata),
    .rq1_lock    (rq1_lock),
    .rq1_ready   (rq1_ready),
    .rq1_rvalid  (rq1_rvalid),
    .rq1_rdata   (rq1_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .arb_owner   (arb_owner),
    .arb_lock_err(arb_lock_err)
  );

  function automatic logic [DW-1:0] pat(int i);
    return DW'(32'h1357_0000 + i * 41);
  endfunction

  // Behavioural RAM; read data is garbage on cycles with no read strobe.
  logic          ram_clear;
  logic [DW-1:0] tb_ram [DEPTH];
  always @(posedge mc_clk) begin
    if (ram_clear) begin
      for (int i = 0; i < DEPTH; i++) tb_ram[i] <= pat(i);
    end else if (mem_en && mem_we) begin
      tb_ram[mem_addr] <= mem_wdata;
    end
    if (mem_en && !mem_we) mem_rdata <= tb_ram[mem_addr];
    else                   mem_rdata <= $urandom;
  end

  // Reference model state
  int            m_lock;     // -1: nobody holds a lock
  int            m_ptr;
  int            m_idle;
  bit            m_err;
  int            m_owner;
  logic [DW-1:0] mem_model [DEPTH];
  exp_t          sb_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic rq_t mk(bit v, bit we, bit lk, int a, logic [DW-1:0] d);
    rq_t r;
    r.v  = v;
    r.we = we;
    r.lk = lk;
    r.a  = AW'(a);
    r.d  = d;
    return r;
  endfunction

  function automatic int model_grant(bit v0, bit v1);
    if (m_lock == 0) return v0 ? 0 : -1;
    if (m_lock == 1) return v1 ? 1 : -1;
    if (v0 && v1)    return m_ptr;
    if (v0)          return 0;
    if (v1)          return 1;
    return -1;
  endfunction

  task automatic model_update(input int g, input rq_t r0, input rq_t r1);
    rq_t r;
    r = (g == 1) ? r1 : r0;
    if (g >= 0) begin
      m_owner = g;
      if (r.we) mem_model[r.a] = r.d;
      if (m_lock < 0) begin
        m_ptr = 1 - g;
        if (r.lk) begin
          m_lock = g;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
        if (!r.lk) begin
          m_lock = -1;
          m_ptr  = 1 - g;
        end
      end
    end else if (m_lock >= 0) begin
      m_idle++;
      if (m_idle >= LM) begin
        m_err  = 1'b1;
        m_ptr  = 1 - m_lock;
        m_lock = -1;
        m_idle = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_lock  = -1;
    m_ptr   = 0;
    m_idle  = 0;
    m_err   = 1'b0;
    m_owner = 0;
    sb_q.delete();
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, advance model.
  task automatic step(input rq_t r0, input rq_t r1);
    int         g;
    rq_t        r;
    logic [VW-1:0] ev, av;
    rq0_valid = r0.v; rq0_we = r0.we; rq0_lock = r0.lk; rq0_addr = r0.a; rq0_wdata = r0.d;
    rq1_valid = r1.v; rq1_we = r1.we; rq1_lock = r1.lk; rq1_addr = r1.a; rq1_wdata = r1.d;
    @(negedge mc_clk);
    g  = model_grant(r0.v, r1.v);
    r  = (g == 1) ? r1 : r0;
    if (g >= 0)
      ev = {g == 1, g == 0, 1'b1, r.we, r.a, r.d, m_owner == 1, m_err};
    else
      ev = {1'b0, 1'b0, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, m_owner == 1, m_err};
    av = {rq1_ready, rq0_ready, mem_en, mem_we, mem_addr, mem_wdata, arb_owner, arb_lock_err};
    check("grant_cmd", 64'(av), 64'(ev));
    if (g >= 0 && !r.we) sb_q.push_back('{cyc + 1, g, mem_model[r.a]});
    @(posedge mc_clk);
    model_update(g, r0, r1);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    mc_reset = 1'b1;
    model_reset();
    repeat (n) begin
      @(negedge mc_clk);
      check("reset_ctl", 64'({rq0_ready, rq1_ready, rq0_rvalid, rq1_rvalid, mem_en, mem_we,
                              arb_owner, arb_lock_err}), 64'd0);
      check("reset_bus", 64'({mem_addr, mem_wdata}), 64'd0);
      check("reset_rdata", {rq0_rdata, rq1_rdata}, 64'd0);
      @(posedge mc_clk);
      cyc++;
      #1;
    end
    mc_reset = 1'b0;
  endtask

  // Read-return monitor: every cycle, rvalid/rdata must match the queue head
  // when it is due, and be all zero otherwise.
  task automatic monitor();
    forever begin
      @(negedge mc_clk);
      begin
        logic [1:0]    ev;
        logic [DW-1:0] e0, e1;
        exp_t          e;
        ev = 2'b00;
        e0 = '0;
        e1 = '0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
          e = sb_q.pop_front();
          ev = (e.who == 1) ? 2'b10 : 2'b01;
          if (e.who == 1) e1 = e.data;
          else            e0 = e.data;
        end
        check("rvalid", 64'({rq1_rvalid, rq0_rvalid}), 64'(ev));
        check("rdata", {rq1_rdata, rq0_rdata}, {e1, e0});
      end
    end
  endtask

  rq_t idle_rq;
  rq_t a, b;

  initial begin
    mc_reset  = 1'b1;
    ram_clear = 1'b1;
    idle_rq   = mk(0, 0, 0, 0, '0);
    rq0_valid = 0; rq0_we = 0; rq0_lock = 0; rq0_addr = '0; rq0_wdata = '0;
    rq1_valid = 0; rq1_we = 0; rq1_lock = 0; rq1_addr = '0; rq1_wdata = '0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = pat(i);
    model_reset();
    fork
      monitor();
    join_none
    @(posedge mc_clk);
    #1;
    ram_clear = 1'b0;
    do_reset(2);

    // Both read from reset: grants alternate rq0, rq1, rq0, rq1.
    for (int i = 0; i < 4; i++) step(mk(1, 0, 0, 5, '0), mk(1, 0, 0, 9, '0));
    step(idle_rq, idle_rq);

    // Write then read the same address on the next cycle from the other side.
    step(mk(1, 1, 0, 3, 32'hDEAD_BEEF), idle_rq);
    step(idle_rq, mk(1, 0, 0, 3, '0));
    step(idle_rq, idle_rq);

    // rq1 lock burst while rq0 keeps requesting.
    step(mk(1, 0, 0, 1, '0), idle_rq);
    step(mk(1, 0, 0, 2, '0), mk(1, 1, 1, 20, 32'h1111_0000));
    step(mk(1, 0, 0, 2, '0), mk(1, 1, 1, 21, 32'h1111_0001));
    step(mk(1, 0, 0, 2, '0), mk(1, 0, 1, 20, '0));
    step(mk(1, 0, 0, 2, '0), mk(1, 0, 0, 21, '0));
    step(mk(1, 0, 0, 2, '0), idle_rq);
    step(idle_rq, idle_rq);

    // rq0 takes a lock then goes quiet; rq1 waits out the timeout.
    step(mk(1, 1, 1, 7, 32'hCAFE_0007), idle_rq);
    for (int i = 0; i < LM + 2; i++) step(idle_rq, mk(1, 0, 0, 7, '0));
    check("lock_err_sticky", 64'(arb_lock_err), 64'd1);
    step(idle_rq, idle_rq);

    // Reset lands in the cycle after a read accept: the return is dropped.
    step(mk(1, 0, 0, 9, '0), idle_rq);
    do_reset(2);
    step(idle_rq, idle_rq);
    step(idle_rq, idle_rq);

    // rq1 alone, eight back-to-back reads.
    for (int i = 0; i < 8; i++) step(idle_rq, mk(1, 0, 0, 40 + i, '0));
    step(idle_rq, idle_rq);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      a = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
             int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      b = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
             int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      step(a, b);
    end

    step(idle_rq, idle_rq);
    step(idle_rq, idle_rq);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL provide these parameters:
- ADDR_W, default 7, memory address width.
- DATA_W, default 32, memory data width.
- LOCK_MAX, default 64, maximum idle cycles a lock may be held.

REQ-002 The block SHALL provide these ports; reset is mc_reset, asynchronous, active-high; clock is mc_clk:
- mc_clk  in  1  clock.
- mc_reset  in  1  asynchronous active-high reset.
- rq0_valid  in  1  requester 0 (input loader) beat request.
- rq0_we  in  1  1=write, 0=read.
- rq0_addr  in  ADDR_W  address.
- rq0_wdata  in  DATA_W  write data.
- rq0_lock  in  1  hold grant after this beat.
- rq0_ready  out  1  beat accepted this cycle.
- rq0_rvalid  out  1  read data valid.
- rq0_rdata  out  DATA_W  read data.
- rq1_*  same set  requester 1 (FPU operand fetch).
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0.
- arb_owner  out  1  requester granted most recently.
- arb_lock_err  out  1  sticky lock-timeout flag.

Function
REQ-003 Beat acceptance SHALL be rqN_valid && rqN_ready; at most one rqN_ready SHALL be high per cycle.
REQ-004 rqN_ready SHALL be combinational from the valids, the state and the priority pointer: zero-cycle grant.
REQ-005 The mem_* outputs SHALL be combinational copies of the granted requester's we/addr/wdata, with mem_en=1 only on acceptance; otherwise mem_en=0, mem_we=0, addr and wdata=0.
REQ-006 State machine: IDLE, LOCK0, LOCK1.
REQ-007 In IDLE with a single valid, that requester SHALL be granted.
REQ-008 In IDLE with both valid, the requester selected by the priority pointer SHALL be granted.
REQ-009 After each IDLE acceptance by requester N, the pointer SHALL move to 1-N (round-robin).
REQ-010 Acceptance with rqN_lock=1 SHALL move the state to LOCKN.
REQ-011 In LOCKN only requester N SHALL be granted; the other requester's ready SHALL stay 0.
REQ-012 In LOCKN, an accepted beat with rqN_lock=0 SHALL return the state to IDLE and set the pointer to 1-N.
REQ-013 In LOCKN, an 8-bit idle counter SHALL count cycles without an accepted beat and clear on every accepted beat.
REQ-014 When the idle counter reaches LOCK_MAX, the block SHALL force IDLE, set the pointer to 1-N, and set arb_lock_err=1; the flag is cleared only by reset.
REQ-015 Read return: a 1-bit in-flight flag plus a requester tag SHALL be registered on read acceptance.
REQ-016 rqN_rvalid SHALL pulse exactly one cycle after the accepting cycle, for the tagged requester only.
REQ-017 rqN_rdata SHALL equal mem_rdata while rqN_rvalid=1 and 0 otherwise.
REQ-018 Back-to-back reads (one per cycle) SHALL return in order with no bubbles.
REQ-019 Write accepts SHALL produce no rvalid.
REQ-020 The block SHALL perform no forwarding: read-after-write ordering is purely by acceptance order.
REQ-021 arb_owner SHALL register the index of the last accepted requester.
REQ-022 The block SHALL perform no address arithmetic; addresses pass through unchanged at ADDR_W bits.

Reset
REQ-023 While mc_reset=1:
- state=IDLE, pointer=0, idle counter=0, in-flight flag=0;
- arb_owner=0, arb_lock_err=0;
- all rqN_ready, rqN_rvalid, rqN_rdata=0 and mem_en, mem_we, mem_addr, mem_wdata=0.
REQ-024 Reset asserted mid-lock or with a read in flight SHALL discard the pending rvalid; no rvalid SHALL follow reset release.

Structure
REQ-025 ADDR_W, DATA_W, LOCK_MAX and the 2-bit state encoding (IDLE=00, LOCK0=01, LOCK1=10) SHALL live in shared package mem_pkg, also used by mem_ctrl.
REQ-026 The block SHALL be a single module with no sub-modules; the RAM is instantiated at top level beside it.

Verification
REQ-027 Both valid from reset, both reads, addresses 5 and 9 held for 4 cycles -> grants alternate rq0, rq1, rq0, rq1; each rvalid arrives exactly 1 cycle after its grant.
REQ-028 rq0 writes 0xDEADBEEF to address 3, then rq1 reads address 3 the next cycle -> rq1_rdata=0xDEADBEEF with rq1_rvalid high, 1 cycle after the read grant.
REQ-029 rq1 lock burst of 4 beats (lock=1,1,1,0) with rq0_valid held high -> rq0_ready stays 0 until the 5th cycle, then rq0 is granted.
REQ-030 rq0 accepts with lock=1, then drops valid and rq1 waits -> after 64 idle cycles arb_lock_err=1 and rq1 is granted the next cycle.
REQ-031 mc_reset pulsed in the cycle after a read accept -> no rvalid appears and all outputs are 0 during reset.
REQ-032 Single requester rq1 alone, 8 consecutive reads -> ready high every cycle, 8 rvalids with no gaps.
